// File: rtl/seg7_pkg.sv
// seg7_pkg: segment encodings, BCD-to-segment lookup and counter width helper
package seg7_pkg;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH = 8'h01;
  localparam logic [15:0][7:0] SEG_TABLE = {{6{SEG_DASH}}, 8'h7B, 8'h7F, 8'h70, 8'h5F, 8'h5B,
                                            8'h33, 8'h79, 8'h6D, 8'h30, 8'h7E};
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    return SEG_TABLE[d];
  endfunction
  function automatic int prescale_w(input int tc);
    return tc < 2 ? 1 : $clog2(tc + 1);
  endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: value capture, display control and scanned display outputs
interface seg7_scan_driver_if #(parameter int VALUE_W = 7, parameter int NUM_DIGITS = 2);
  logic [VALUE_W-1:0] value_in;
  logic value_valid;
  logic blink_en;
  logic blank_lead;
  logic [7:0] seg;
  logic [NUM_DIGITS-1:0] scan_select;
  logic busy;
  modport master (output value_in, value_valid, blink_en, blank_lead, input seg, scan_select, busy);
  modport slave (input value_in, value_valid, blink_en, blank_lead, output seg, scan_select, busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, VALUE_W shift cycles, one-cycle done pulse with result
module bin2bcd_seq #(
  parameter int VALUE_W = 7,
  parameter int NUM_DIGITS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic run_o,
  output logic done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic ovf_o
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(VALUE_W + 1);
  localparam int MAX_VAL = 10 ** NUM_DIGITS - 1;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d, done_q, done_d, ovf_q, ovf_d;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    bin_d = start_i ? value_i : run_q ? bin_q << 1 : bin_q;
    bcd_d = start_i ? '0 : run_q ? {adj[BW-2:0], bin_q[VALUE_W-1]} : bcd_q;
    cnt_d = start_i ? CW'(VALUE_W) : run_q ? cnt_q - CW'(1) : cnt_q;
    run_d = start_i | (run_q & (cnt_q != CW'(1)));
    done_d = run_q & (cnt_q == CW'(1));
    ovf_d = start_i ? (32'(value_i) > 32'(MAX_VAL)) : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
  assign run_o = run_q;
  assign done_o = done_q;
  assign bcd_o = bcd_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: capture/pending control, BCD display regs, scan ring, blink and segment output
module seg7_scan_driver import seg7_pkg::*; #(
  parameter int CLK_HZ = 100_000_000,
  parameter int SCAN_HZ = 400,
  parameter int BLINK_HZ = 2,
  parameter int NUM_DIGITS = 2,
  parameter int VALUE_W = 7
) (
  input logic clk,
  input logic reset,
  seg7_scan_driver_if.slave bus
);
  localparam int SCAN_TC = CLK_HZ / SCAN_HZ - 1;
  localparam int BLINK_TC = CLK_HZ / (2 * BLINK_HZ) - 1;
  localparam int SW = prescale_w(SCAN_TC);
  localparam int KW = prescale_w(BLINK_TC);
  localparam int BW = 4 * NUM_DIGITS;
  logic start, conv_run, conv_done, conv_ovf, tick, blink_wrap, lz;
  logic [VALUE_W-1:0] start_val, pend_val_q, pend_val_d;
  logic pend_v_q, pend_v_d, busy_q, disp_ovf_q, disp_ovf_d, phase_q, phase_d;
  logic [BW-1:0] conv_bcd, disp_bcd_q, disp_bcd_d;
  logic [SW-1:0] presc_q, presc_d;
  logic [KW-1:0] blink_cnt_q, blink_cnt_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [NUM_DIGITS-1:0][7:0] enc;
  logic [7:0] seg_q, seg_d, seg_sel;
  logic [3:0] dig;
  bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk(clk), .reset(reset), .start_i(start), .value_i(start_val),
    .run_o(conv_run), .done_o(conv_done), .bcd_o(conv_bcd), .ovf_o(conv_ovf)
  );
  // a strobe landing on the completion cycle is a fresh capture and drops any pending value
  always_comb begin
    start = ~conv_run & (bus.value_valid | (pend_v_q & ~conv_done));
    start_val = bus.value_valid ? bus.value_in : pend_val_q;
    pend_v_d = (bus.value_valid & conv_run) | (pend_v_q & ~start);
    pend_val_d = (bus.value_valid & conv_run) ? bus.value_in : pend_val_q;
    disp_bcd_d = conv_done ? conv_bcd : disp_bcd_q;
    disp_ovf_d = conv_done ? conv_ovf : disp_ovf_q;
    tick = presc_q == SW'(SCAN_TC);
    presc_d = tick ? '0 : presc_q + SW'(1);
    sel_d = tick ? (sel_q << 1) | (sel_q >> (NUM_DIGITS - 1)) : sel_q;
    blink_wrap = blink_cnt_q == KW'(BLINK_TC);
    blink_cnt_d = (~bus.blink_en | blink_wrap) ? '0 : blink_cnt_q + KW'(1);
    phase_d = ~bus.blink_en ? 1'b1 : blink_wrap ? ~phase_q : phase_q;
  end
  // seg is built from next-state values so it always matches the digit selected alongside it
  always_comb begin
    enc = '0;
    lz = 1'b1;
    dig = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig = disp_bcd_d[4*i +: 4];
      lz = lz & (dig == 4'd0) & (i != 0);
      enc[i] = disp_ovf_d ? SEG_DASH : (bus.blank_lead & lz) ? SEG_BLANK : bcd_to_seg(dig);
    end
    seg_sel = SEG_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) seg_sel = sel_d[i] ? enc[i] : seg_sel;
    seg_d = phase_d ? seg_sel : SEG_BLANK;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_v_q <= 1'b0;
      pend_val_q <= '0;
      busy_q <= 1'b0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
      presc_q <= '0;
      blink_cnt_q <= '0;
      phase_q <= 1'b1;
      sel_q <= NUM_DIGITS'(1);
      seg_q <= SEG_BLANK;
    end else begin
      pend_v_q <= pend_v_d;
      pend_val_q <= pend_val_d;
      busy_q <= conv_run;
      disp_bcd_q <= disp_bcd_d;
      disp_ovf_q <= disp_ovf_d;
      presc_q <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q <= phase_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end
  assign bus.seg = seg_q;
  assign bus.scan_select = sel_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed vectors for capture, pending, blanking, range, blink and reset abort
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic seen25 = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  seg7_scan_driver_if #(.VALUE_W(7), .NUM_DIGITS(2)) bus ();
  seg7_scan_driver #(.CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(10), .NUM_DIGITS(2), .VALUE_W(7))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.scan_select == 2'b01 && bus.seg == 8'h5B) seen25 = 1'b1;
  endtask
  task automatic strobe(input logic [6:0] v);
    bus.value_in = v;
    bus.value_valid = 1'b1;
    step();
    bus.value_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 40) begin
      step();
      n++;
    end
    check(tag, 16'(n < 40), 16'd1);
  endtask
  task automatic read_digits(output logic [7:0] d1, output logic [7:0] d0);
    d1 = 8'hEE;
    d0 = 8'hEE;
    repeat (25) begin
      step();
      if (bus.scan_select == 2'b01) d0 = bus.seg;
      if (bus.scan_select == 2'b10) d1 = bus.seg;
    end
  endtask
  initial begin
    logic [7:0] d1, d0;
    int cnt;
    bus.value_in = '0;
    bus.value_valid = 1'b0;
    bus.blink_en = 1'b0;
    bus.blank_lead = 1'b0;
    repeat (3) step();
    check("rst_seg", 16'(bus.seg), 16'h00);
    check("rst_sel", 16'(bus.scan_select), 16'h1);
    check("rst_busy", 16'(bus.busy), 16'h0);
    reset = 1'b1;
    repeat (9) step();
    check("pre_tick_sel", 16'(bus.scan_select), 16'h1);
    check("pre_tick_seg", 16'(bus.seg), 16'h7E);
    step();
    check("first_tick_sel", 16'(bus.scan_select), 16'h2);
    strobe(7'd42);
    check("busy_lag", 16'(bus.busy), 16'h0);
    step();
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      cnt++;
      step();
    end
    check("busy_len", 16'(cnt), 16'd7);
    read_digits(d1, d0);
    check("v42_d1", 16'(d1), 16'h33);
    check("v42_d0", 16'(d0), 16'h6D);
    bus.blank_lead = 1'b1;
    strobe(7'd7);
    wait_idle("idle7");
    read_digits(d1, d0);
    check("v7_blank_d1", 16'(d1), 16'h00);
    check("v7_blank_d0", 16'(d0), 16'h70);
    bus.blank_lead = 1'b0;
    read_digits(d1, d0);
    check("v7_noblank_d1", 16'(d1), 16'h7E);
    bus.blank_lead = 1'b1;
    strobe(7'd0);
    wait_idle("idle0");
    read_digits(d1, d0);
    check("v0_d1", 16'(d1), 16'h00);
    check("v0_d0", 16'(d0), 16'h7E);
    strobe(7'd10);
    strobe(7'd25);
    step();
    strobe(7'd99);
    wait_idle("idle10");
    check("show10", 16'(bus.seg), bus.scan_select == 2'b10 ? 16'h30 : 16'h7E);
    step();
    check("pend_gap", 16'(bus.busy), 16'h0);
    step();
    check("pend_start", 16'(bus.busy), 16'h1);
    wait_idle("idle99");
    read_digits(d1, d0);
    check("v99_d1", 16'(d1), 16'h7B);
    check("v99_d0", 16'(d0), 16'h7B);
    check("no25", 16'(seen25), 16'h0);
    bus.blank_lead = 1'b0;
    strobe(7'd120);
    wait_idle("idle120");
    read_digits(d1, d0);
    check("v120_d1", 16'(d1), 16'h01);
    check("v120_d0", 16'(d0), 16'h01);
    bus.blink_en = 1'b1;
    repeat (49) step();
    check("blink_on_a", 16'(bus.seg), 16'h01);
    step();
    check("blink_off_a", 16'(bus.seg), 16'h00);
    repeat (49) step();
    check("blink_off_b", 16'(bus.seg), 16'h00);
    step();
    check("blink_on_b", 16'(bus.seg), 16'h01);
    repeat (50) step();
    check("blink_off_c", 16'(bus.seg), 16'h00);
    bus.blink_en = 1'b0;
    step();
    check("blink_clear", 16'(bus.seg), 16'h01);
    strobe(7'd55);
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort_busy", 16'(bus.busy), 16'h0);
    cnt = 0;
    repeat (30) begin
      step();
      if (bus.busy) cnt++;
    end
    check("abort_quiet", 16'(cnt), 16'd0);
    read_digits(d1, d0);
    check("abort_d1", 16'(d1), 16'h7E);
    check("abort_d0", 16'(d0), 16'h7E);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
